// File: rtl/uart_rx.sv
// UART receiver: 8E1 frames, 16x oversampling, memory-mapped data/status.
// Level IRQ follows the rx_valid flag.
module uart_rx #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter logic [31:0] ADDR_DATA   = 32'h1000_0010,
    parameter logic [31:0] ADDR_STATUS = 32'h1000_0014
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] r_addr_i,
    input  logic        r_enable_i,
    input  logic [31:0] w_addr_i,
    input  logic [31:0] w_data_i,
    input  logic        w_enable_i,
    output logic [31:0] data_o,
    output logic        irq_o,
    input  logic        rx
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [DW-1:0] div_q;
    logic [3:0]    s_q;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          perr_q, perr_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          pe_q, pe_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic [31:0]   data_q, data_d;

    logic tick, samp, start, commit, stop_bad, accept;
    logic data_rd, stat_rd, stat_wr, busy;
    logic [2:0] clr;

    assign tick = (div_q == DW'(DIV - 1));
    assign samp = tick && (s_q == 4'd7);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        perr_d   = perr_q;
        start    = 1'b0;
        commit   = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    start   = 1'b1;
                end
            end
            S_START: begin
                if (samp) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (samp) begin
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (samp) begin
                    perr_d  = rx_s_q ^ (^shift_q);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (samp) begin
                    commit = 1'b1;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A commit racing a DATA read hands the old byte out and loads the new one
    always_comb begin
        data_rd = r_enable_i && (r_addr_i == ADDR_DATA);
        stat_rd = r_enable_i && (r_addr_i == ADDR_STATUS);
        stat_wr = w_enable_i && (w_addr_i == ADDR_STATUS);
        clr     = stat_wr ? w_data_i[3:1] : 3'b000;
        busy    = (state_q != S_IDLE);
        accept  = commit && (!valid_q || data_rd);
        byte_d  = accept ? shift_q : byte_q;
        valid_d = accept ? 1'b1 : (data_rd ? 1'b0 : valid_q);
        pe_d    = (pe_q & ~clr[0]) | (accept & perr_q);
        fe_d    = (fe_q & ~clr[1]) | (accept & stop_bad);
        ov_d    = (ov_q & ~clr[2]) | (commit & ~accept);
        data_d  = data_q;
        if (data_rd) begin
            data_d = {24'b0, byte_q};
        end else if (stat_rd) begin
            data_d = {27'b0, busy, ov_q, fe_q, pe_q, valid_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            s_q       <= 4'd0;
            shift_q   <= 8'd0;
            idx_q     <= 3'd0;
            perr_q    <= 1'b0;
            byte_q    <= 8'd0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            data_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            if (start) begin
                div_q <= '0;
                s_q   <= 4'd0;
            end else if (tick) begin
                div_q <= '0;
                s_q   <= s_q + 4'd1;
            end else begin
                div_q <= div_q + DW'(1);
            end
            shift_q <= shift_d;
            idx_q   <= idx_d;
            perr_q  <= perr_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;
    assign irq_o  = valid_q;

endmodule
